dezigzag: RTL and testbench

- Inverse of the zigzag reorder stage on the decode path.
- Accepts one 8x8 block of quantised DCT coefficients in JPEG zigzag scan order, one coefficient per valid cycle.
- Emits the block in raster order: row-major, position = row*8 + col.
- Ping-pong (double) buffered so that a continuous 1-per-cycle input stream produces a continuous output stream with no stalls. It feeds the inverse DCT stage.

---
 rtl/dezigzag.sv | 125 ++++++++++++
 tb/tb_dezigzag.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/dezigzag.sv
// dezigzag: reorders one 8x8 block of coefficients from JPEG zigzag scan
// order into raster order (row*8 + col) ahead of the inverse DCT.
// Ping-pong buffered: one bank fills while the other drains, so a gap-free
// 1-per-cycle input stream gives a gap-free output stream.
//
// Read FSM
//   state   | meaning
//   --------+----------------------------------------------------------
//   ST_IDLE | no bank being drained; rd_cnt is 0; waiting for full[rd_bank]
//   ST_READ | draining bank rd_bank in raster order, one coefficient/cycle
//
// A bank is read in the same cycle its full flag is first seen, even from
// ST_IDLE. This gives the two-cycle input-to-output latency. It also keeps
// the output gap-free when the writer fills the other bank in the same cycle
// that the reader finishes the current one.
module dezigzag #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    output logic [DATA_W-1:0] dout,
    output logic              dout_valid,
    output logic              dout_last
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_READ = 1'b1;

    // Zigzag index -> raster address (standard JPEG scan).
    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    logic [DATA_W-1:0] bank0 [64];
    logic [DATA_W-1:0] bank1 [64];

    logic [5:0] wr_cnt;
    logic       wr_bank;
    logic [5:0] rd_cnt;
    logic       rd_bank;
    logic [1:0] full;
    logic [0:0] state;

    logic       rd_go;
    logic       wr_done;
    logic       rd_done;
    logic [1:0] set_mask;
    logic [1:0] clr_mask;

    // Decide whether a coefficient is read this cycle and which flags change.
    always_comb begin
        rd_go    = (state == ST_READ) || full[rd_bank];
        wr_done  = din_valid && (wr_cnt == 6'd63);
        rd_done  = rd_go && (rd_cnt == 6'd63);
        set_mask = 2'b00;
        clr_mask = 2'b00;
        if (wr_done) set_mask[wr_bank] = 1'b1;
        if (rd_done) clr_mask[rd_bank] = 1'b1;
    end

    // Scatter incoming zigzag-ordered coefficients to their raster slot.
    always_ff @(posedge clk) begin
        if (din_valid) begin
            if (wr_bank) bank1[ZZ[wr_cnt]] <= din;
            else         bank0[ZZ[wr_cnt]] <= din;
        end
    end

    // Write counter and bank select; the bank flips after the 64th sample.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            wr_cnt  <= 6'd0;
            wr_bank <= 1'b0;
        end else if (din_valid) begin
            wr_cnt <= wr_cnt + 6'd1;
            if (wr_cnt == 6'd63) wr_bank <= ~wr_bank;
        end
    end

    // Bank-full flags: set by the writer, cleared by the reader (never the same bank at once).
    always_ff @(posedge clk) begin
        if (!nrst) full <= 2'b00;
        else       full <= (full & ~clr_mask) | set_mask;
    end

    // Read FSM: walk the bank in raster order, chaining into the other bank if it is ready.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state   <= ST_IDLE;
            rd_cnt  <= 6'd0;
            rd_bank <= 1'b0;
        end else if (rd_go) begin
            rd_cnt <= rd_cnt + 6'd1;
            if (rd_cnt == 6'd63) begin
                rd_bank <= ~rd_bank;
                state   <= full[~rd_bank] ? ST_READ : ST_IDLE;
            end else begin
                state <= ST_READ;
            end
        end
    end

    // Output register; dout holds its value between blocks.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
        end else begin
            dout_valid <= rd_go;
            dout_last  <= rd_done;
            if (rd_go) dout <= rd_bank ? bank1[rd_cnt] : bank0[rd_cnt];
        end
    end

endmodule

// File: tb/tb_dezigzag.sv
// Directed testbench for dezigzag: single block, back-to-back blocks, gapped
// input, reset while filling, reset while draining and a long random run.
module tb_dezigzag;

    typedef logic [7:0] blk_t [64];

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic [7:0] din = 8'd0;
    logic       din_valid = 1'b0;
    logic [7:0] dout;
    logic       dout_valid;
    logic       dout_last;

    dezigzag #(.DATA_W(8)) dut (
        .clk        (clk),
        .nrst       (nrst),
        .din        (din),
        .din_valid  (din_valid),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_last  (dout_last)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] out_q  [$];
    logic       last_q [$];
    int         cyc_q  [$];
    logic [7:0] exp_q  [$];

    always @(negedge clk) begin
        if (dout_valid === 1'b1) begin
            out_q.push_back(dout);
            last_q.push_back(dout_last);
            cyc_q.push_back(cyc);
        end
    end

    localparam int ZZ_T [64] = '{
        0, 1, 8,16, 9, 2, 3,10,17,24,32,25,18,11, 4, 5,
       12,19,26,33,40,48,41,34,27,20,13, 6, 7,14,21,28,
       35,42,49,56,57,50,43,36,29,22,15,23,30,37,44,51,
       58,59,52,45,38,31,39,46,53,60,61,54,47,55,62,63};

    int n_assert = 0;
    int n_fail   = 0;
    int last_cyc = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push_exp(input blk_t blk);
        logic [7:0] ras [64];
        for (int k = 0; k < 64; k++) ras[ZZ_T[k]] = blk[k];
        for (int p = 0; p < 64; p++) exp_q.push_back(ras[p]);
    endtask

    // gap < 0 selects a random gap of 0..3 idle cycles after each sample.
    task automatic send_block(input blk_t blk, input int n_send, input int gap);
        int g;
        for (int k = 0; k < n_send; k++) begin
            din       = blk[k];
            din_valid = 1'b1;
            last_cyc  = cyc;
            @(posedge clk); #1;
            din_valid = 1'b0;
            g = (gap < 0) ? int'($urandom_range(0, 3)) : gap;
            repeat (g) begin
                din = 8'($urandom);
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic clear_q();
        out_q.delete(); last_q.delete(); cyc_q.delete(); exp_q.delete();
    endtask

    task automatic wait_outs(input int n);
        int budget = 0;
        while (out_q.size() < n && budget < 3000) begin
            @(posedge clk); #1;
            budget++;
        end
        repeat (10) @(posedge clk);
        #1;
    endtask

    // Compare captured output against exp_q; first_cyc < 0 skips the latency check.
    task automatic check_stream(input string tag, input int first_cyc, input bit contiguous);
        int n;
        int n_last = 0;
        chk({tag, " count"}, out_q.size(), exp_q.size());
        n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
        if (n > 0 && first_cyc >= 0) chk({tag, " latency"}, cyc_q[0], first_cyc);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s data[%0d]", tag, i), out_q[i], exp_q[i]);
            chk($sformatf("%s last[%0d]", tag, i), last_q[i], (i % 64) == 63);
            if (i > 0 && ((i % 64) != 0 || contiguous))
                chk($sformatf("%s gap[%0d]", tag, i), cyc_q[i] - cyc_q[i-1], 1);
            if (last_q[i] === 1'b1) n_last++;
        end
        chk({tag, " last count"}, n_last, exp_q.size() / 64);
        clear_q();
    endtask

    initial begin
        blk_t blk;
        int   c0;
        int   seen;
        int   budget;

        // Reset state
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dout", dout, 0);
        chk("reset dout_valid", dout_valid, 0);
        chk("reset dout_last", dout_last, 0);
        nrst = 1'b1;
        @(posedge clk); #1;

        // Single block, din = k
        for (int k = 0; k < 64; k++) blk[k] = 8'(k);
        push_exp(blk);
        send_block(blk, 64, 0);
        c0 = last_cyc;
        wait_outs(64);
        if (out_q.size() == 64) begin
            chk("blk1 hand[1]", out_q[1], 1);
            chk("blk1 hand[2]", out_q[2], 5);
            chk("blk1 hand[8]", out_q[8], 2);
            chk("blk1 hand[15]", out_q[15], 42);
            chk("blk1 hand[56]", out_q[56], 35);
            chk("blk1 hand[62]", out_q[62], 62);
        end
        check_stream("blk1", c0 + 2, 1'b1);

        // Three back-to-back blocks
        for (int b = 0; b < 3; b++) begin
            for (int k = 0; k < 64; k++) blk[k] = 8'(k + 64 * b);
            push_exp(blk);
            send_block(blk, 64, 0);
            if (b == 0) c0 = last_cyc;
        end
        wait_outs(192);
        check_stream("b2b", c0 + 2, 1'b1);

        // Gapped input, valid every third cycle
        for (int k = 0; k < 64; k++) blk[k] = 8'(k);
        push_exp(blk);
        send_block(blk, 64, 2);
        c0 = last_cyc;
        wait_outs(64);
        check_stream("gap3", c0 + 2, 1'b1);

        // Reset after 30 samples, then a full block
        for (int k = 0; k < 64; k++) blk[k] = 8'(k + 8'h55);
        send_block(blk, 30, 0);
        nrst = 1'b0;
        @(posedge clk); #1;
        nrst = 1'b1;
        clear_q();
        for (int k = 0; k < 64; k++) blk[k] = 8'(8'hA0 + k);
        push_exp(blk);
        send_block(blk, 64, 0);
        c0 = last_cyc;
        wait_outs(64);
        if (out_q.size() >= 3) begin
            chk("rstfill first", out_q[0], 8'hA0);
            chk("rstfill second", out_q[1], 8'hA1);
            chk("rstfill third", out_q[2], 8'hA5);
        end
        check_stream("rstfill", c0 + 2, 1'b1);

        // Reset on output cycle 20 of a draining block
        for (int k = 0; k < 64; k++) blk[k] = 8'(k ^ 8'h5A);
        send_block(blk, 64, 0);
        seen = 0;
        budget = 0;
        while (seen < 20 && budget < 200) begin
            @(posedge clk); #1;
            seen = out_q.size() + ((dout_valid === 1'b1) ? 1 : 0);
            budget++;
        end
        chk("rstdrain reached", seen, 20);
        nrst = 1'b0;
        @(posedge clk); #1;
        chk("rstdrain dout_valid", dout_valid, 0);
        chk("rstdrain dout_last", dout_last, 0);
        nrst = 1'b1;
        repeat (100) @(posedge clk);
        #1;
        chk("rstdrain no more outputs", out_q.size(), 20);
        clear_q();
        for (int k = 0; k < 64; k++) blk[k] = 8'(255 - k);
        push_exp(blk);
        send_block(blk, 64, 0);
        c0 = last_cyc;
        wait_outs(64);
        check_stream("after rstdrain", c0 + 2, 1'b1);

        // Random blocks with random gaps
        for (int b = 0; b < 200; b++) begin
            for (int k = 0; k < 64; k++) blk[k] = 8'($urandom);
            push_exp(blk);
            send_block(blk, 64, -1);
        end
        wait_outs(200 * 64);
        check_stream("random", -1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
